// File: rtl/ll_keypad_if.sv
// Keypad bundle: raw pushbuttons and lock in, thrust/select results out.
interface ll_keypad_if;
  logic [20:0] pb;
  logic        lock;
  logic [15:0] thrust;
  logic        thrust_upd;
  logic [1:0]  disp_sel;

  // Keypad block side
  modport slave (
    input  pb,
    input  lock,
    output thrust,
    output thrust_upd,
    output disp_sel
  );

  // Board / lander-control side
  modport master (
    output pb,
    output lock,
    input  thrust,
    input  thrust_upd,
    input  disp_sel
  );
endinterface

// File: rtl/ll_keypad.sv
// Lunar-lander keypad: synchronizes pushbuttons, debounces a key pattern,
// and turns accepted single presses into a BCD thrust digit or a display select.
module ll_keypad #(
  parameter int unsigned DEBOUNCE    = 3,
  parameter logic [15:0] THRUST_INIT = 16'h0005,
  parameter logic [1:0]  SEL_INIT    = 2'd0
) (
  input logic       clk,
  input logic       rst,
  ll_keypad_if.slave kp
);

  localparam int unsigned KEY_W = 14;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t             state;
  logic [KEY_W-1:0]   sync1;
  logic [KEY_W-1:0]   keys;
  logic [KEY_W-1:0]   sample;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        thrust_q;
  logic               upd_q;
  logic [1:0]         sel_q;

  logic [KEY_W-1:0]   pb_used;
  logic               unused_pb;
  logic               is_digit_c;
  logic               is_sel_c;
  logic [3:0]         digit_c;
  logic [1:0]         sel_c;

  // Keep only select keys (Z,Y,X,W) and digits 0-9; remaining buttons are don't-care
  assign pb_used   = {kp.pb[19:16], kp.pb[9:0]};
  assign unused_pb = ^{kp.pb[20], kp.pb[15:10]};

  // Classify the latched pattern: lone digit, lone select key, or neither
  always_comb begin
    is_digit_c = $onehot(sample) && (sample[13:10] == 4'b0000);
    is_sel_c   = $onehot(sample) && (sample[9:0] == 10'b0);
    digit_c    = 4'd0;
    sel_c      = 2'd0;
    for (int i = 0; i < 10; i++) begin
      if (sample[i]) digit_c = 4'(i);
    end
    // sample[13]=Z->0, [12]=Y->1, [11]=X->2, [10]=W->3
    for (int i = 0; i < 4; i++) begin
      if (sample[10+i]) sel_c = 2'(3 - i);
    end
  end

  // Synchronizer, debounce FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      keys     <= '0;
      state    <= IDLE;
      sample   <= '0;
      cnt      <= '0;
      thrust_q <= THRUST_INIT;
      sel_q    <= SEL_INIT;
      upd_q    <= 1'b0;
    end else begin
      sync1 <= pb_used;
      keys  <= sync1;
      upd_q <= 1'b0;
      case (state)
        IDLE: begin
          if (keys != '0) begin
            sample <= keys;
            cnt    <= CNT_W'(1);
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (keys != sample) begin
            state <= IDLE;
          end else if (cnt < DEB) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            // Pattern stable long enough: act on it once, then wait for release
            if (is_digit_c && !kp.lock) begin
              thrust_q <= {12'h000, digit_c};
              upd_q    <= 1'b1;
            end else if (is_sel_c) begin
              sel_q <= sel_c;
            end
            state <= HELD;
          end
        end
        HELD: begin
          if (keys == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign kp.thrust     = thrust_q;
  assign kp.thrust_upd = upd_q;
  assign kp.disp_sel   = sel_q;

endmodule

// File: tb/tb_ll_keypad.sv
// Directed bench for ll_keypad with an event scoreboard for thrust pulses
// and display-select changes.
module tb_ll_keypad;

  logic clk;
  logic rst;

  ll_keypad_if kp ();

  ll_keypad #(
    .DEBOUNCE   (3),
    .THRUST_INIT(16'h0005),
    .SEL_INIT   (2'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp.slave)
  );

  typedef struct {
    bit          is_thr;
    logic [15:0] val;
  } ev_t;

  ev_t  expq[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic [1:0] prev_sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare any output event seen this cycle against the scoreboard head
  task automatic mon();
    ev_t e;
    if (rst) begin
      prev_sel = kp.disp_sel;
    end else begin
      if (kp.thrust_upd === 1'b1) begin
        if (expq.size() == 0) begin
          chk("unexpected_thrust_upd", kp.thrust, 16'hxxxx);
        end else begin
          e = expq.pop_front();
          chk("sb_kind_thr", {15'd0, e.is_thr}, 16'd1);
          chk("sb_thrust", kp.thrust, e.val);
        end
      end
      if (kp.disp_sel !== prev_sel) begin
        if (expq.size() == 0) begin
          chk("unexpected_disp_sel", {14'd0, kp.disp_sel}, {14'd0, prev_sel});
        end else begin
          e = expq.pop_front();
          chk("sb_kind_sel", {15'd0, e.is_thr}, 16'd0);
          chk("sb_disp_sel", {14'd0, kp.disp_sel}, e.val);
        end
      end
      prev_sel = kp.disp_sel;
    end
  endtask

  // One clock edge, then observe on the falling edge
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      mon();
    end
  endtask

  task automatic push(input bit is_thr, input logic [15:0] v);
    ev_t e;
    e.is_thr = is_thr;
    e.val    = v;
    expq.push_back(e);
  endtask

  function automatic logic [20:0] bit21(input int b);
    logic [20:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  initial begin
    rst      = 1'b1;
    kp.pb    = '0;
    kp.lock  = 1'b0;
    prev_sel = 2'd0;

    // Async reset values before any clock edge
    #2;
    chk("rst_thrust", kp.thrust, 16'h0005);
    chk("rst_sel", {14'd0, kp.disp_sel}, 16'd0);
    chk("rst_upd", {15'd0, kp.thrust_upd}, 16'd0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // Digit 9 held 12 edges: commit on edge 6, single pulse
    kp.pb = bit21(9);
    push(1'b1, 16'h0009);
    cyc(5);
    chk("d9_pre_thrust", kp.thrust, 16'h0005);
    chk("d9_pre_upd", {15'd0, kp.thrust_upd}, 16'd0);
    cyc(1);
    chk("d9_thrust", kp.thrust, 16'h0009);
    chk("d9_upd", {15'd0, kp.thrust_upd}, 16'd1);
    cyc(1);
    chk("d9_upd_drop", {15'd0, kp.thrust_upd}, 16'd0);
    cyc(5);
    kp.pb = '0;
    cyc(5);
    chk("d9_release_thrust", kp.thrust, 16'h0009);

    // Short glitch on digit 3 is rejected
    kp.pb = bit21(3);
    cyc(2);
    kp.pb = '0;
    cyc(8);
    chk("glitch_thrust", kp.thrust, 16'h0009);
    chk("glitch_sel", {14'd0, kp.disp_sel}, 16'd0);

    // Two digits together: no change
    kp.pb = bit21(2) | bit21(7);
    cyc(10);
    chk("multi_thrust", kp.thrust, 16'h0009);
    kp.pb = '0;
    cyc(4);

    // Y selects velocity
    kp.pb = bit21(18);
    push(1'b0, 16'd1);
    cyc(5);
    chk("y_pre_sel", {14'd0, kp.disp_sel}, 16'd0);
    cyc(1);
    chk("y_sel", {14'd0, kp.disp_sel}, 16'd1);
    kp.pb = '0;
    cyc(4);

    // Fresh reset, then lock blocks digit 0 but not select W
    rst = 1'b1;
    #1;
    chk("rst2_sel", {14'd0, kp.disp_sel}, 16'd0);
    cyc(1);
    rst = 1'b0;
    kp.lock = 1'b1;
    kp.pb = bit21(0);
    cyc(8);
    chk("lock_thrust", kp.thrust, 16'h0005);
    kp.pb = '0;
    cyc(4);
    kp.pb = bit21(16);
    push(1'b0, 16'd3);
    cyc(6);
    chk("w_sel", {14'd0, kp.disp_sel}, 16'd3);
    kp.pb = '0;
    cyc(4);
    kp.lock = 1'b0;

    // Reset mid-WAIT aborts; held key gets full latency again
    kp.pb = bit21(4);
    cyc(4);
    rst = 1'b1;
    #1;
    chk("abort_sel", {14'd0, kp.disp_sel}, 16'd0);
    chk("abort_thrust", kp.thrust, 16'h0005);
    cyc(1);
    rst = 1'b0;
    push(1'b1, 16'h0004);
    cyc(5);
    chk("abort_pre_thrust", kp.thrust, 16'h0005);
    cyc(1);
    chk("abort_thrust4", kp.thrust, 16'h0004);
    chk("abort_upd", {15'd0, kp.thrust_upd}, 16'd1);
    kp.pb = '0;
    cyc(4);

    // Re-press same digit still pulses; change while held is ignored
    kp.pb = bit21(4);
    push(1'b1, 16'h0004);
    cyc(6);
    chk("repress_upd", {15'd0, kp.thrust_upd}, 16'd1);
    kp.pb = bit21(5);
    cyc(8);
    chk("held_change_thrust", kp.thrust, 16'h0004);
    kp.pb = '0;
    cyc(4);

    // Ignored button bit alone does nothing
    kp.pb = bit21(12);
    cyc(10);
    chk("ignored_thrust", kp.thrust, 16'h0004);
    kp.pb = '0;
    cyc(4);

    chk("sb_empty", 16'(expq.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ll_keypad.md
LL_KEYPAD -- requirements
Module: ll_keypad

Interface
REQ-001 Parameter DEBOUNCE, default 3: cycles a key pattern must stay stable before it is accepted; legal range 1..255.
REQ-002 Parameter THRUST_INIT, default 16'h0005: BCD thrust value loaded at reset.
REQ-003 Parameter SEL_INIT, default 2'd0: display-select value loaded at reset.
REQ-004 clk  input  1  system clock (100 Hz board clock).
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 pb  input  21  raw asynchronous pushbuttons; pb[9:0] are digits 0-9; pb[19] Z, pb[18] Y, pb[17] X, pb[16] W; all other bits are ignored.
REQ-007 lock  input  1  asserted by lander control on land or crash; blocks thrust changes.
REQ-008 thrust  output  16  registered BCD thrust, {12'h000, digit}; feeds the lander memory thrust_n input.
REQ-009 thrust_upd  output  1  registered one-cycle pulse, high in the cycle after thrust takes a new accepted value.
REQ-010 disp_sel  output  2  registered display select: 0 altitude (Z), 1 velocity (Y), 2 fuel (X), 3 thrust (W).

Function
REQ-011 pb SHALL pass through a two-flop synchronizer; only bits 19:16 and 9:0 of the synchronized vector ("keys", 14 bits) SHALL be used downstream.
REQ-012 The block SHALL implement an FSM with states IDLE, WAIT and HELD, plus an 8-bit stability counter cnt and a 14-bit latched pattern sample.
REQ-013 IDLE: if keys != 0 on an edge, latch sample = keys, set cnt = 1 and go to WAIT; otherwise stay in IDLE.
REQ-014 WAIT: if keys != sample, go to IDLE with no action (glitch rejected).
REQ-015 WAIT: if keys == sample and cnt < DEBOUNCE, increment cnt and stay in WAIT.
REQ-016 WAIT: if keys == sample and cnt == DEBOUNCE, commit the sample (REQ-018..021) on that edge and go to HELD.
REQ-017 HELD: stay while keys != 0; go to IDLE on the first edge where keys == 0. There is no auto-repeat, and a pattern change while held is ignored.
REQ-018 Commit, sample with exactly one digit bit d set and no other bits: if lock == 0, thrust <= {12'h000, 4'(d)} and thrust_upd <= 1; if lock == 1, there is no change.
REQ-019 Commit, sample with exactly one select bit set and no other bits: disp_sel <= encoding per REQ-010, regardless of lock; thrust is unchanged.
REQ-020 Commit, sample with more than one bit set (any mix): no output changes; the FSM still goes to HELD.
REQ-021 thrust_upd SHALL be 0 on every edge except the commit edge of REQ-018, so it is exactly one cycle wide.
REQ-022 Re-pressing the current digit SHALL still pulse thrust_upd, with thrust unchanged.
REQ-023 Latency: with the key applied before edge 1 and held, outputs SHALL change on edge DEBOUNCE+3 (2 synchronizer edges, 1 IDLE edge, DEBOUNCE WAIT edges).
REQ-024 lock is sampled at the commit edge only; changes to lock at other times have no effect.
REQ-025 thrust SHALL always hold valid BCD in the range 16'h0000..16'h0009.

Reset
REQ-026 While rst is high, the synchronizer flops, sample and cnt SHALL be 0, the state SHALL be IDLE, thrust SHALL be THRUST_INIT, disp_sel SHALL be SEL_INIT, and thrust_upd SHALL be 0, all asynchronously.
REQ-027 rst asserted in any state, including mid-WAIT or HELD, SHALL abort the operation; a key still held after release of rst is treated as a new press with full latency.

Verification (DEBOUNCE=3)
REQ-028 Pulse rst -> thrust=16'h0005, disp_sel=0, thrust_upd=0 with no clock edge required.
REQ-029 pb[9] held from before edge 1 for 12 edges -> thrust=16'h0009 after edge 6, thrust_upd high for exactly one cycle after edge 6, and no further pulse while held or on release.
REQ-030 pb[3] high for 2 edges only -> thrust, disp_sel and thrust_upd unchanged.
REQ-031 pb[2]|pb[7] held 10 edges -> no change; release both, then pb[18] held -> disp_sel=1 after edge 6 of that press.
REQ-032 lock=1 with pb[0] held -> thrust stays 16'h0005 and thrust_upd stays 0; next, pb[16] held -> disp_sel=3.
REQ-033 pb[4] held; rst pulsed at edge 4 (WAIT); pb[4] still held -> thrust=16'h0004 exactly DEBOUNCE+3 edges after rst release.
